alu_issue_stage: RTL

//  ID->EX issue stage sitting directly upstream of ALU32Bit. Latches decoded register operands,

---
 rtl/alu_issue_stage_if.sv | 47 ++++
 rtl/alu_issue_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// Handshake bundles around the ALU issue stage: the decoded item coming in
// from decode and the ALU work item going out to EX.
interface alu_issue_in_if #(
  parameter int BITS_SIZE = 32,
  parameter int REG_BITS  = 5
);
  logic                 InValid;
  logic                 InReady;
  logic [BITS_SIZE-1:0] RD1;
  logic [BITS_SIZE-1:0] RD2;
  logic [15:0]          Imm16;
  logic                 ALUSrc;
  logic [1:0]           ALUOp;
  logic [5:0]           Funct;
  logic [REG_BITS-1:0]  DestIn;

  modport master (
    output InValid, RD1, RD2, Imm16, ALUSrc, ALUOp, Funct, DestIn,
    input  InReady
  );
  modport slave (
    input  InValid, RD1, RD2, Imm16, ALUSrc, ALUOp, Funct, DestIn,
    output InReady
  );
endinterface

interface alu_issue_out_if #(
  parameter int BITS_SIZE = 32,
  parameter int REG_BITS  = 5
);
  logic                 OutValid;
  logic                 OutReady;
  logic [BITS_SIZE-1:0] A;
  logic [BITS_SIZE-1:0] B;
  logic [3:0]           ALUControl;
  logic [REG_BITS-1:0]  DestOut;
  logic                 IllegalOp;

  modport master (
    output OutValid, A, B, ALUControl, DestOut, IllegalOp,
    input  OutReady
  );
  modport slave (
    input  OutValid, A, B, ALUControl, DestOut, IllegalOp,
    output OutReady
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes ALU operands/control and hands items to the ALU
// through a 2-entry skid buffer so InReady is always a flop output.
module alu_issue_stage #(
  parameter int BITS_SIZE = 32,
  parameter int REG_BITS  = 5
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Flush,
  alu_issue_in_if.slave   up,
  alu_issue_out_if.master dn
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [BITS_SIZE-1:0] a;
    logic [BITS_SIZE-1:0] b;
    logic [3:0]           ctrl;
    logic [REG_BITS-1:0]  dest;
    logic                 illegal;
  } item_t;

  // Returns {illegal, ALUControl}.
  function automatic logic [4:0] decode_ctrl(input logic [1:0] op, input logic [5:0] funct);
    logic [4:0] res;
    case (op)
      2'b00: res = 5'b0_0010;
      2'b01: res = 5'b0_0110;
      2'b11: res = 5'b0_0001;
      2'b10: begin
        case (funct)
          6'h20:   res = 5'b0_0010;
          6'h22:   res = 5'b0_0110;
          6'h24:   res = 5'b0_0000;
          6'h25:   res = 5'b0_0001;
          6'h27:   res = 5'b0_1100;
          6'h2A:   res = 5'b0_0111;
          default: res = 5'b1_1111;
        endcase
      end
      default: res = 5'b1_1111;
    endcase
    return res;
  endfunction

  state_e state_q, state_d;
  item_t  head_q, head_d;
  item_t  skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  item_t  new_item_s;
  logic   in_fire_s;
  logic   out_fire_s;

  assign in_fire_s  = up.InValid & in_ready_q;
  assign out_fire_s = out_valid_q & dn.OutReady;

  // Build the item that would be captured from the current decode inputs.
  always_comb begin
    new_item_s      = '0;
    new_item_s.a    = up.RD1;
    if (up.ALUSrc) begin
      new_item_s.b = {{(BITS_SIZE-16){up.Imm16[15]}}, up.Imm16};
    end else begin
      new_item_s.b = up.RD2;
    end
    {new_item_s.illegal, new_item_s.ctrl} = decode_ctrl(up.ALUOp, up.Funct);
    new_item_s.dest = up.DestIn;
  end

  // Occupancy state machine; head is always the item presented to EX.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            head_d  = new_item_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && !out_fire_s) begin
            skid_d  = new_item_s;
            state_d = ST_FULL;
          end else if (!in_fire_s && out_fire_s) begin
            state_d = ST_EMPTY;
          end else if (in_fire_s && out_fire_s) begin
            head_d  = new_item_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // InReady is low here, so the input side cannot fire.
          if (out_fire_s) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State, buffer entries and registered handshake outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign up.InReady    = in_ready_q;
  assign dn.OutValid   = out_valid_q;
  assign dn.A          = head_q.a;
  assign dn.B          = head_q.b;
  assign dn.ALUControl = head_q.ctrl;
  assign dn.DestOut    = head_q.dest;
  assign dn.IllegalOp  = head_q.illegal;

endmodule
